soc_system_sysid_checker: RTL and testbench

Avalon-MM master that reads the two words of the system-ID slave: word 0 is the ID and word 1 is the build timestamp. It compares both against expected values and reports pass/fail to boot-control logic.
- Sits directly upstream of the sysid slave and drives its address/read inputs.
- Gates HPS/fabric bring-up, which waits on done/id_ok.
- The slave is zero-wait with fixed read latency; no waitrequest.

---
 rtl/soc_system_sysid_checker.sv | 267 ++++++++++++++++++++++++++
 tb/tb_soc_system_sysid_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_sysid_checker
//  Description : Avalon-MM read master for the system-ID slave. It reads
//                word 0 (ID) and word 1 (build timestamp), compares each word
//                with its expected value and reports the result to the
//                boot-control logic that gates HPS/fabric bring-up.
//
//  Ports
//    clock            system clock
//    reset_n          synchronous active-low reset (sampled on rising clock)
//    start            single-cycle request, accepted only in IDLE
//    sysid_address    Avalon address (0 = ID, 1 = timestamp)
//    sysid_read       Avalon read strobe, one cycle per access
//    sysid_readdata   Avalon readdata from the sysid slave
//    busy             high while a check sequence is in flight
//    done             one-cycle pulse when the check completes
//    id_ok / ts_ok    compare results, valid from done until next start
//    id_value         last captured ID word
//    ts_value         last captured timestamp word
//    retry_count      retries used by the last check
//
//  Build option
//    SYSID_CHECK_RETRY_EN : when defined, a mismatch re-reads both words up
//                           to MAX_RETRIES extra times before reporting.
//
//  Revision    : 1.0 - initial release
// ============================================================================

module soc_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS  = 32'h57117CE3,
    parameter int          READ_LATENCY = 0,
    parameter int          MAX_RETRIES  = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);

    // ------------------------------------------------------------------------
    // Parameter range guards (elaboration time only)
    // ------------------------------------------------------------------------
    generate
        if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_read_latency
            $error("soc_system_sysid_checker: READ_LATENCY must be 0..3");
        end
        if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_max_retries
            $error("soc_system_sysid_checker: MAX_RETRIES must be 1..15");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_ID = 3'd1;
    localparam logic [2:0] S_RD_TS = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] c_lat_last = READ_LATENCY[1:0];

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [1:0]  r_lat_cnt;
    logic        w_lat_last;
    logic        w_rd_state;
    logic        w_id_match;
    logic        w_ts_match;
    logic        w_retry_take;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    assign w_rd_state = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_lat_last = (r_lat_cnt == c_lat_last);
    assign w_id_match = (r_id_value == EXPECTED_ID);
    assign w_ts_match = (r_ts_value == EXPECTED_TS);

    // ------------------------------------------------------------------------
    // Optional retry logic
    // ------------------------------------------------------------------------
`ifdef SYSID_CHECK_RETRY_EN
    localparam logic [3:0] c_max_retries = MAX_RETRIES[3:0];

    logic [3:0] r_retry_count;

    // The limit test makes the counter saturate at MAX_RETRIES.
    assign w_retry_take = (r_state == S_CHECK)
                       && !(w_id_match && w_ts_match)
                       && (r_retry_count < c_max_retries);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_retry_count <= 4'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_retry_count <= 4'd0;
        end else if (w_retry_take) begin
            r_retry_count <= r_retry_count + 4'd1;
        end
    end

    assign retry_count = r_retry_count;
`else
    assign w_retry_take = 1'b0;
    assign retry_count  = 4'd0;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RD_ID;
                end
            end
            S_RD_ID: begin
                if (w_lat_last) begin
                    w_next_state = S_RD_TS;
                end
            end
            S_RD_TS: begin
                if (w_lat_last) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_retry_take) begin
                    w_next_state = S_RD_ID;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately not sampled here; only IDLE accepts it
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        sysid_address = 1'b0;
        sysid_read    = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_RD_ID: begin
                busy          = 1'b1;
                sysid_address = 1'b0;
                // strobe only in the first cycle of the access
                sysid_read    = (r_lat_cnt == 2'd0);
            end
            S_RD_TS: begin
                busy          = 1'b1;
                sysid_address = 1'b1;
                sysid_read    = (r_lat_cnt == 2'd0);
            end
            S_CHECK: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read latency counter: counts 0..READ_LATENCY inside each read state and
    // returns to 0 on the capture edge so the next access starts fresh.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_lat_cnt <= 2'd0;
        end else if (w_rd_state && !w_lat_last) begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
        end else begin
            r_lat_cnt <= 2'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Capture and compare registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_id_ok    <= 1'b0;
                        r_ts_ok    <= 1'b0;
                        r_id_value <= 32'd0;
                        r_ts_value <= 32'd0;
                    end
                end
                S_RD_ID: begin
                    if (w_lat_last) begin
                        r_id_value <= sysid_readdata;
                    end
                end
                S_RD_TS: begin
                    if (w_lat_last) begin
                        r_ts_value <= sysid_readdata;
                    end
                end
                S_CHECK: begin
                    r_id_ok <= w_id_match;
                    r_ts_ok <= w_ts_match;
                end
                default: begin
                    r_id_ok <= r_id_ok;
                end
            endcase
        end
    end

    assign id_ok    = r_id_ok;
    assign ts_ok    = r_ts_ok;
    assign id_value = r_id_value;
    assign ts_value = r_ts_value;

endmodule

`default_nettype wire

// File: tb/tb_soc_system_sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_system_sysid_checker
//  Description : Directed self-checking bench. Two checker instances are
//                used: one with READ_LATENCY=0 against a combinational slave
//                model, one with READ_LATENCY=2 against a pipelined slave
//                model whose data is only valid exactly two cycles after the
//                strobe (garbage otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_soc_system_sysid_checker;

    localparam logic [31:0] c_id      = 32'hACD51302;
    localparam logic [31:0] c_ts      = 32'h57117CE3;
    localparam logic [31:0] c_garbage = 32'h0BAD0BAD;

    logic        clock;
    logic        reset_n;
    logic        start0, start2;
    logic        addr0, addr2, read0, read2;
    logic [31:0] rdata0, rdata2;
    logic        busy0, busy2, done0, done2;
    logic        idok0, idok2, tsok0, tsok2;
    logic [31:0] idv0, idv2, tsv0, tsv2;
    logic [3:0]  rc0, rc2;

    logic [31:0] id_word, ts_word;
    logic        p1, p2, a1, a2;

    int n_vec        = 0;
    int n_miscompare = 0;

    // per-run observations
    int   sel;
    int   n_reads, n_dones, done_cyc;
    int   rd_cyc [2];
    logic rd_addr [2];
    logic busy3, read3;

    soc_system_sysid_checker #(
        .READ_LATENCY (0)
    ) u_dut0 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start0),
        .sysid_address  (addr0),
        .sysid_read     (read0),
        .sysid_readdata (rdata0),
        .busy           (busy0),
        .done           (done0),
        .id_ok          (idok0),
        .ts_ok          (tsok0),
        .id_value       (idv0),
        .ts_value       (tsv0),
        .retry_count    (rc0)
    );

    soc_system_sysid_checker #(
        .READ_LATENCY (2)
    ) u_dut2 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start2),
        .sysid_address  (addr2),
        .sysid_read     (read2),
        .sysid_readdata (rdata2),
        .busy           (busy2),
        .done           (done2),
        .id_ok          (idok2),
        .ts_ok          (tsok2),
        .id_value       (idv2),
        .ts_value       (tsv2),
        .retry_count    (rc2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // combinational slave: data valid only in the strobe cycle
    always_comb begin
        rdata0 = c_garbage;
        if (read0) begin
            rdata0 = addr0 ? ts_word : id_word;
        end
    end

    // two-cycle-latency slave: data valid only two cycles after the strobe
    always_ff @(posedge clock) begin
        p1 <= read2;
        a1 <= addr2;
        p2 <= p1;
        a2 <= a1;
    end

    always_comb begin
        rdata2 = c_garbage;
        if (p2) begin
            rdata2 = a2 ? ts_word : id_word;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a check on the selected instance in cycle 0, then observe cycles
    // 1..n_cycles. Optional extra start pulse / reset pulse in given cycles.
    task automatic run(input int which, input logic [31:0] idw, input logic [31:0] tsw,
                       input int extra_start, input int rst_cyc, input bit fix_id,
                       input int n_cycles);
        logic r, a, d;
        sel      = which;
        id_word  = idw;
        ts_word  = tsw;
        n_reads  = 0;
        n_dones  = 0;
        done_cyc = -1;
        rd_cyc[0] = -1; rd_cyc[1] = -1;
        rd_addr[0] = 1'bx; rd_addr[1] = 1'bx;
        busy3 = 1'bx; read3 = 1'bx;
        if (which == 0) start0 = 1'b1; else start2 = 1'b1;
        for (int n = 1; n <= n_cycles; n++) begin
            @(posedge clock);
            #1;
            r = (which == 0) ? read0 : read2;
            a = (which == 0) ? addr0 : addr2;
            d = (which == 0) ? done0 : done2;
            if (r) begin
                if (n_reads < 2) begin
                    rd_cyc[n_reads]  = n;
                    rd_addr[n_reads] = a;
                end
                n_reads++;
            end
            if (d) begin
                if (done_cyc < 0) done_cyc = n;
                n_dones++;
            end
            if (n == 3) begin
                busy3 = (which == 0) ? busy0 : busy2;
                read3 = r;
            end
            if (fix_id && n_reads == 2 && !r) id_word = c_id;
            start0  = 1'b0;
            start2  = 1'b0;
            reset_n = 1'b1;
            if (n == extra_start) begin
                if (which == 0) start0 = 1'b1; else start2 = 1'b1;
            end
            if (n == rst_cyc) reset_n = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start0  = 1'b0;
        start2  = 1'b0;
        id_word = c_id;
        ts_word = c_ts;
        sel     = 0;
        repeat (3) @(posedge clock);
        #1;
        // reset state
        check_vec("rst_busy0",  {31'd0, busy0}, 32'd0);
        check_vec("rst_done0",  {31'd0, done0}, 32'd0);
        check_vec("rst_read0",  {31'd0, read0}, 32'd0);
        check_vec("rst_idok0",  {31'd0, idok0}, 32'd0);
        check_vec("rst_idv0",   idv0, 32'd0);
        check_vec("rst_rc0",    {28'd0, rc0}, 32'd0);
        check_vec("rst_busy2",  {31'd0, busy2}, 32'd0);
        check_vec("rst_tsv2",   tsv2, 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 1: latency 0, matching words
        run(0, c_id, c_ts, -1, -1, 1'b0, 12);
        check_vec("t1_nreads",  n_reads, 2);
        check_vec("t1_rd0_cyc", rd_cyc[0], 1);
        check_vec("t1_rd0_adr", {31'd0, rd_addr[0]}, 32'd0);
        check_vec("t1_rd1_cyc", rd_cyc[1], 2);
        check_vec("t1_rd1_adr", {31'd0, rd_addr[1]}, 32'd1);
        check_vec("t1_busy3",   {31'd0, busy3}, 32'd1);
        check_vec("t1_done",    done_cyc, 4);
        check_vec("t1_ndone",   n_dones, 1);
        check_vec("t1_idok",    {31'd0, idok0}, 32'd1);
        check_vec("t1_tsok",    {31'd0, tsok0}, 32'd1);
        check_vec("t1_idv",     idv0, c_id);
        check_vec("t1_tsv",     tsv0, c_ts);
        check_vec("t1_rc",      {28'd0, rc0}, 32'd0);
        check_vec("t1_busy_end",{31'd0, busy0}, 32'd0);

        // 2: latency 2, matching words
        run(2, c_id, c_ts, -1, -1, 1'b0, 14);
        check_vec("t2_nreads",  n_reads, 2);
        check_vec("t2_rd0_cyc", rd_cyc[0], 1);
        check_vec("t2_rd1_cyc", rd_cyc[1], 4);
        check_vec("t2_done",    done_cyc, 8);
        check_vec("t2_idok",    {31'd0, idok2}, 32'd1);
        check_vec("t2_tsok",    {31'd0, tsok2}, 32'd1);
        check_vec("t2_tsv",     tsv2, c_ts);

        // 3: wrong ID
        run(0, 32'hDEADBEEF, c_ts, -1, -1, 1'b0, 24);
        check_vec("t3_idok",    {31'd0, idok0}, 32'd0);
        check_vec("t3_tsok",    {31'd0, tsok0}, 32'd1);
        check_vec("t3_idv",     idv0, 32'hDEADBEEF);
        check_vec("t3_ndone",   n_dones, 1);
`ifdef SYSID_CHECK_RETRY_EN
        check_vec("t3_nreads",  n_reads, 8);
        check_vec("t3_rc",      {28'd0, rc0}, 32'd3);
`else
        check_vec("t3_nreads",  n_reads, 2);
        check_vec("t3_done",    done_cyc, 4);
        check_vec("t3_rc",      {28'd0, rc0}, 32'd0);
`endif

        // ID off by a single LSB, wrong timestamp: full-width compare
        run(2, 32'hACD51303, 32'h57117CE2, -1, -1, 1'b0, 40);
        check_vec("t3b_idok",   {31'd0, idok2}, 32'd0);
        check_vec("t3b_tsok",   {31'd0, tsok2}, 32'd0);
        check_vec("t3b_tsv",    tsv2, 32'h57117CE2);

`ifdef SYSID_CHECK_RETRY_EN
        // 4: wrong on the first pass only
        run(0, 32'h12345678, c_ts, -1, -1, 1'b1, 24);
        check_vec("t4_rc",      {28'd0, rc0}, 32'd1);
        check_vec("t4_idok",    {31'd0, idok0}, 32'd1);
        check_vec("t4_tsok",    {31'd0, tsok0}, 32'd1);
        check_vec("t4_nreads",  n_reads, 4);
        check_vec("t4_ndone",   n_dones, 1);
`endif

        // 5: start while busy, and start during DONE, are both ignored
        run(0, c_id, c_ts, 2, -1, 1'b0, 14);
        check_vec("t5_nreads",  n_reads, 2);
        check_vec("t5_ndone",   n_dones, 1);
        check_vec("t5_done",    done_cyc, 4);
        run(0, c_id, c_ts, 4, -1, 1'b0, 14);
        check_vec("t5b_nreads", n_reads, 2);
        check_vec("t5b_ndone",  n_dones, 1);

        // 6: reset during RD_TS aborts without done
        run(0, c_id, c_ts, -1, 2, 1'b0, 12);
        check_vec("t6_busy3",   {31'd0, busy3}, 32'd0);
        check_vec("t6_read3",   {31'd0, read3}, 32'd0);
        check_vec("t6_ndone",   n_dones, 0);
        check_vec("t6_nreads",  n_reads, 2);
        check_vec("t6_idv",     idv0, 32'd0);
        run(0, c_id, c_ts, -1, -1, 1'b0, 12);
        check_vec("t6_re_done", done_cyc, 4);
        check_vec("t6_re_idok", {31'd0, idok0}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule

`default_nettype wire
